// File: rtl/lc3b_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lc3b_pkg
//  Description : Shared LC-3b constants and types.
//                - GPR_ADDR_W : general-purpose register index width
//                - WORD_W     : datapath word width
//                - NUM_GPR    : number of general-purpose registers
//                - dump_state_t : state encoding of the register dump engine
//  Revision    : 1.0 - initial release
// ============================================================================
package lc3b_pkg;

    localparam int GPR_ADDR_W = 3;
    localparam int WORD_W     = 16;
    localparam int NUM_GPR    = 8;

    // Register dump engine states. Encoding is fixed so that trace tools
    // decoding the raw state value stay in step with the RTL.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_CAPT    = 2'd2,
        ST_PRESENT = 2'd3
    } dump_state_t;

endpackage : lc3b_pkg
`default_nettype wire

// File: rtl/reg_dump.sv
`default_nettype none
// ============================================================================
//  Module      : reg_dump
//  Description : Debug read-out engine for the LC-3b register file.
//                On a start pulse it walks R0..R(NUM_REGS-1) through the
//                SR1 read port, captures each registered read value and
//                presents it as one beat on a valid/ready stream. While the
//                dump is in progress rf_hold is raised so the control unit
//                suppresses LD_REG and the dump is a consistent snapshot.
//
//  Ports       : clk        - system clock, rising edge
//                reset      - synchronous, active-high reset
//                start      - request a dump (sampled only when idle)
//                busy       - engine active
//                rf_hold    - write-hold to the control unit (== busy)
//                rf_sr      - register file SR1 read address
//                rf_data    - register file SR1_OUT (one-cycle read latency)
//                out_valid  - beat valid
//                out_ready  - sink accepts the beat
//                out_idx    - register index of the current beat
//                out_data   - register value of the current beat
//                done       - one-cycle pulse after the last beat is taken
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_dump
    import lc3b_pkg::*;
#(
    parameter int NUM_REGS = NUM_GPR,
    parameter int ADDR_W   = GPR_ADDR_W,
    parameter int DATA_W   = WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              rf_hold,
    output logic [ADDR_W-1:0] rf_sr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              done
);

    // Terminal index. Comparing against this (rather than letting the
    // counter overflow) means indices above NUM_REGS-1 are never issued.
    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(NUM_REGS - 1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    dump_state_t        r_state;
    logic [ADDR_W-1:0]  r_idx;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_done;

    // Next-state values
    dump_state_t        w_state_nxt;
    logic [ADDR_W-1:0]  w_idx_nxt;
    logic [DATA_W-1:0]  w_out_data_nxt;
    logic               w_out_valid_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        // Hold everything by default; done is a single-cycle pulse.
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_idx_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end

            // rf_sr already carries r_idx; the register file samples it on
            // this edge and presents the value during CAPT.
            ST_FETCH: begin
                w_state_nxt = ST_CAPT;
            end

            ST_CAPT: begin
                w_out_data_nxt  = rf_data;
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = ST_PRESENT;
            end

            // Hold data, index and read address steady until accepted.
            ST_PRESENT: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    if (r_idx == c_last_idx) begin
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output mapping. busy is kept as its own flop (set on accept, cleared
    // on the final handshake) so every output comes straight off a flop.
    // ------------------------------------------------------------------
    assign busy      = r_busy;
    assign rf_hold   = r_busy;
    assign rf_sr     = r_idx;
    assign out_idx   = r_idx;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign done      = r_done;

endmodule : reg_dump
`default_nettype wire

// File: tb/tb_reg_dump.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_dump
//  Description : Self-checking bench for reg_dump. A register file model
//                with registered read and LD_REG gated by !rf_hold sits
//                beside the DUT. Expected beats are queued when a dump is
//                started and compared as handshakes occur; per-cycle timing
//                is checked against a vector table and hand-written
//                sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_dump;
    import lc3b_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        rf_hold;
    logic [2:0]  rf_sr;
    logic [15:0] rf_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_idx;
    logic [15:0] out_data;
    logic        done;

    // Register-file write side, driven by the bench
    logic        ld_reg;
    logic [2:0]  ld_dr;
    logic [15:0] ld_val;

    always #5 clk = ~clk;

    reg_dump #(
        .NUM_REGS (8),
        .ADDR_W   (3),
        .DATA_W   (16)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .rf_hold   (rf_hold),
        .rf_sr     (rf_sr),
        .rf_data   (rf_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .done      (done)
    );

    // Register file: registered read, writes suppressed while rf_hold
    logic [15:0] regs [8];
    always_ff @(posedge clk) begin
        if (ld_reg && !rf_hold)
            regs[ld_dr] <= ld_val;
        rf_data <= regs[rf_sr];
    end

    // ------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] data;
    } beat_t;
    beat_t sb[$];

    logic [15:0] shadow [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Beat monitor: a handshake seen at the negedge completes at the next
    // rising edge, unless reset is asserted.
    always @(negedge clk) begin
        if (!reset && done) done_cnt++;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", 32'(out_idx), 32'hFFFF_FFFF);
            end else begin
                beat_t b;
                b = sb.pop_front();
                check("beat_idx", 32'(out_idx), 32'(b.idx));
                check("beat_data", 32'(out_data), 32'(b.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input int i, input logic [15:0] v);
        ld_reg = 1'b1;
        ld_dr  = 3'(i);
        ld_val = v;
        tick();
        ld_reg = 1'b0;
        shadow[i] = v;
    endtask

    task automatic push_dump();
        for (int i = 0; i < 8; i++) begin
            beat_t b;
            b.idx  = 3'(i);
            b.data = shadow[i];
            sb.push_back(b);
        end
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            start = 1'b0;
            if (done) seen = 1;
        end
        check("done_within_budget", 32'(seen), 32'd1);
    endtask

    // Full-dump timing table
    typedef struct {
        int         cyc;
        logic       valid;
        logic [2:0] idx;
        logic       busy;
        logic       done;
    } vec_t;
    vec_t tbl [11];

    initial begin
        tbl[0]  = '{1,  1'b0, 3'd0, 1'b1, 1'b0};
        tbl[1]  = '{2,  1'b0, 3'd0, 1'b1, 1'b0};
        tbl[2]  = '{3,  1'b1, 3'd0, 1'b1, 1'b0};
        tbl[3]  = '{4,  1'b0, 3'd1, 1'b1, 1'b0};
        tbl[4]  = '{6,  1'b1, 3'd1, 1'b1, 1'b0};
        tbl[5]  = '{9,  1'b1, 3'd2, 1'b1, 1'b0};
        tbl[6]  = '{21, 1'b1, 3'd6, 1'b1, 1'b0};
        tbl[7]  = '{23, 1'b0, 3'd7, 1'b1, 1'b0};
        tbl[8]  = '{24, 1'b1, 3'd7, 1'b1, 1'b0};
        tbl[9]  = '{25, 1'b0, 3'd7, 1'b0, 1'b1};
        tbl[10] = '{26, 1'b0, 3'd7, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        ld_reg = 1'b0; ld_dr = '0; ld_val = '0;
        tick(); tick();

        // ---------------- Reset values ----------------
        check("rst_busy", 32'(busy), 0);
        check("rst_rf_hold", 32'(rf_hold), 0);
        check("rst_rf_sr", 32'(rf_sr), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_idx", 32'(out_idx), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_done", 32'(done), 0);
        reset = 1'b0;
        tick();

        // ---------------- Full dump ----------------
        for (int i = 0; i < 8; i++) write_reg(i, 16'h1000 + 16'(i));
        done_cnt = 0;
        push_dump();
        start = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            for (int r = 0; r < 11; r++) begin
                if (tbl[r].cyc == c) begin
                    check("full_valid", 32'(out_valid), 32'(tbl[r].valid));
                    check("full_idx", 32'(out_idx), 32'(tbl[r].idx));
                    check("full_rf_sr", 32'(rf_sr), 32'(tbl[r].idx));
                    check("full_busy", 32'(busy), 32'(tbl[r].busy));
                    check("full_rf_hold", 32'(rf_hold), 32'(tbl[r].busy));
                    check("full_done", 32'(done), 32'(tbl[r].done));
                end
            end
        end
        check("full_done_count", 32'(done_cnt), 1);
        check("full_sb_empty", 32'(sb.size()), 0);

        // ---------------- Backpressure on idx 2 ----------------
        write_reg(2, 16'hBEEF);
        done_cnt = 0;
        push_dump();
        start = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (c == 9) out_ready = 1'b0;
            if (c == 14) out_ready = 1'b1;
            if (c >= 9 && c <= 13) begin
                check("bp_valid", 32'(out_valid), 1);
                check("bp_idx", 32'(out_idx), 2);
                check("bp_rf_sr", 32'(rf_sr), 2);
                check("bp_data", 32'(out_data), 32'h0000_BEEF);
            end
            if (c == 15 || c == 16) check("bp_gap_valid", 32'(out_valid), 0);
            if (c == 17) begin
                check("bp_next_valid", 32'(out_valid), 1);
                check("bp_next_idx", 32'(out_idx), 3);
            end
            if (c == 30) check("bp_done", 32'(done), 1);
        end
        check("bp_done_count", 32'(done_cnt), 1);

        // ---------------- Start while busy is ignored ----------------
        done_cnt = 0;
        push_dump();
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            start = (c == 5 || c == 14);
            if (c == 25) check("ign_done", 32'(done), 1);
        end
        check("ign_done_count", 32'(done_cnt), 1);
        check("ign_busy_after", 32'(busy), 0);

        // ---------------- Reset mid-dump ----------------
        done_cnt = 0;
        push_dump();
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (c == 10) begin
                reset = 1'b1;
                sb.delete();
            end
            if (c == 11) begin
                reset = 1'b0;
                check("mid_rst_busy", 32'(busy), 0);
                check("mid_rst_rf_sr", 32'(rf_sr), 0);
                check("mid_rst_valid", 32'(out_valid), 0);
                check("mid_rst_idx", 32'(out_idx), 0);
                check("mid_rst_data", 32'(out_data), 0);
                check("mid_rst_done", 32'(done), 0);
            end
        end
        check("mid_rst_no_done", 32'(done_cnt), 0);
        push_dump();
        start = 1'b1;
        wait_done(40);
        check("mid_rst_sb_empty", 32'(sb.size()), 0);

        // ---------------- Back-to-back dumps ----------------
        tick();
        done_cnt = 0;
        push_dump();
        push_dump();
        start = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            tick();
            if (c == 25) check("b2b_first_done", 32'(done), 1);
            if (c == 26) begin
                start = 1'b0;
                check("b2b_busy", 32'(busy), 1);
            end
            if (c == 27) check("b2b_gap_valid", 32'(out_valid), 0);
            if (c == 28) begin
                check("b2b_valid", 32'(out_valid), 1);
                check("b2b_idx", 32'(out_idx), 0);
            end
        end
        wait_done(40);
        tick();
        check("b2b_done_count", 32'(done_cnt), 2);
        check("b2b_sb_empty", 32'(sb.size()), 0);

        // ---------------- Snapshot and data extremes ----------------
        write_reg(0, 16'h0000);
        write_reg(7, 16'hFFFF);
        write_reg(3, 16'h3333);
        push_dump();
        start = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (c == 5) begin
                ld_reg = 1'b1; ld_dr = 3'd3; ld_val = 16'hDEAD;
            end
            if (c == 6) ld_reg = 1'b0;
        end
        // Second dump confirms the held write never landed in R3.
        push_dump();
        start = 1'b1;
        wait_done(40);
        tick();
        check("snap_sb_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_dump
`default_nettype wire
